// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: update sequencer for the two-level branch predictor.
// Clears BHT/PHT after reset, arbitrates two branch-resolution requesters
// round-robin into a small FIFO, and retires each report as an ordered
// RD_BHT -> RD_PHT -> WR read-modify-write on the tables' update ports.
// Optional feature macro: BP_UPD_STATS_EN (adds upd_count / bp_conflict_stall).
// HIST_W must lie in 2..7 so both history and PC bits feed the PHT index.

module bp_update_ctrl #(
    parameter int HIST_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [31:0]       req0_pc,
    input  logic              req0_taken,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [31:0]       req1_pc,
    input  logic              req1_taken,
    output logic [7:0]        bht_addr,
    output logic              bht_we,
    output logic [HIST_W-1:0] bht_wdata,
    input  logic [HIST_W-1:0] bht_rdata,
    output logic [7:0]        pht_addr,
    output logic              pht_we,
    output logic [1:0]        pht_wdata,
    input  logic [1:0]        pht_rdata,
    output logic              init_done,
`ifdef BP_UPD_STATS_EN
    output logic [15:0]       upd_count,
    output logic [15:0]       bp_conflict_stall,
`endif
    output logic              busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD_BHT,
        RD_PHT,
        WR
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        init_idx_q, init_idx_d;
    logic              init_done_q, init_done_d;
    logic              prio_q, prio_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [8:0]        fifo_q [FIFO_DEPTH];
    logic [8:0]        fifo_d [FIFO_DEPTH];
    logic [HIST_W-1:0] hist_q, hist_d;
    logic [7:0]        pht_idx_q, pht_idx_d;

    logic       grant0, grant1, can_push, push, pop;
    logic [8:0] push_entry;
    logic [7:0] head_idx;
    logic       head_taken;
    logic [1:0] ctr_next;

    // Only pc[11:4] indexes the tables; the history MSB shifts out on update.
    logic unused_bits;
    assign unused_bits = ^{req0_pc[31:12], req0_pc[3:0],
                           req1_pc[31:12], req1_pc[3:0], hist_q[HIST_W-1]};

    // Round-robin arbiter and FIFO push/pop bookkeeping.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | ~prio_q);
        grant1     = req1_valid & (~req0_valid |  prio_q);
        can_push   = init_done_q & ~reset & (count_q < DEPTH_C);
        req0_ready = can_push & grant0;
        req1_ready = can_push & grant1;
        push       = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        push_entry = grant0 ? {req0_pc[11:4], req0_taken}
                            : {req1_pc[11:4], req1_taken};
        pop        = (state_q == WR);

        prio_d = prio_q;
        // Pointer only moves when a contested cycle actually enqueued.
        if (push && req0_valid && req1_valid) prio_d = ~prio_q;

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = push_entry;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    assign head_idx   = fifo_q[rd_ptr_q][8:1];
    assign head_taken = fifo_q[rd_ptr_q][0];

    // 2-bit saturating counter update for the head report.
    always_comb begin
        ctr_next = pht_rdata;
        if (head_taken) begin
            if (pht_rdata != 2'b11) ctr_next = pht_rdata + 2'b01;
        end else begin
            if (pht_rdata != 2'b00) ctr_next = pht_rdata - 2'b01;
        end
    end

    // Sequencer next state and table-port drive; reset forces ports idle.
    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        hist_d      = hist_q;
        pht_idx_d   = pht_idx_q;
        bht_addr    = 8'h00;
        bht_we      = 1'b0;
        bht_wdata   = '0;
        pht_addr    = 8'h00;
        pht_we      = 1'b0;
        pht_wdata   = 2'b00;

        unique case (state_q)
            INIT: begin
                bht_addr   = init_idx_q;
                bht_we     = 1'b1;
                pht_addr   = init_idx_q;
                pht_we     = 1'b1;
                pht_wdata  = 2'b10;
                init_idx_d = init_idx_q + 8'd1;
                if (init_idx_q == 8'hFF) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end
            end
            IDLE: begin
                // A report pushed this cycle starts its reads next cycle.
                if (count_q != '0 || push) state_d = RD_BHT;
            end
            RD_BHT: begin
                bht_addr = head_idx;
                state_d  = RD_PHT;
            end
            RD_PHT: begin
                hist_d    = bht_rdata;
                pht_idx_d = {bht_rdata, head_idx[7-HIST_W:0]};
                pht_addr  = pht_idx_d;
                state_d   = WR;
            end
            WR: begin
                bht_addr  = head_idx;
                bht_we    = 1'b1;
                bht_wdata = {hist_q[HIST_W-2:0], head_taken};
                pht_addr  = pht_idx_q;
                pht_we    = 1'b1;
                pht_wdata = ctr_next;
                state_d   = (count_d != '0) ? RD_BHT : IDLE;
            end
            default: state_d = INIT;
        endcase

        if (reset) begin
            bht_addr  = 8'h00;
            bht_we    = 1'b0;
            bht_wdata = '0;
            pht_addr  = 8'h00;
            pht_we    = 1'b0;
            pht_wdata = 2'b00;
        end
    end

    assign init_done = init_done_q & ~reset;
    assign busy      = reset | (state_q != IDLE) | (count_q != '0);

    // State, FIFO and latched read data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            init_idx_q  <= 8'h00;
            init_done_q <= 1'b0;
            prio_q      <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            hist_q      <= '0;
            pht_idx_q   <= 8'h00;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            prio_q      <= prio_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            hist_q      <= hist_d;
            pht_idx_q   <= pht_idx_d;
            fifo_q      <= fifo_d;
        end
    end

`ifdef BP_UPD_STATS_EN
    logic [15:0] upd_count_q, upd_count_d;
    logic [15:0] stall_q, stall_d;
    logic        stall_evt;

    // Saturating retire and back-pressure counters.
    always_comb begin
        stall_evt   = init_done_q & ((req0_valid & ~req0_ready) |
                                     (req1_valid & ~req1_ready));
        upd_count_d = upd_count_q;
        stall_d     = stall_q;
        if (pop && upd_count_q != 16'hFFFF)     upd_count_d = upd_count_q + 16'd1;
        if (stall_evt && stall_q != 16'hFFFF)   stall_d     = stall_q + 16'd1;
    end

    // Statistic counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            upd_count_q <= 16'h0000;
            stall_q     <= 16'h0000;
        end else begin
            upd_count_q <= upd_count_d;
            stall_q     <= stall_d;
        end
    end

    assign upd_count         = upd_count_q;
    assign bp_conflict_stall = stall_q;
`endif

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Bench for bp_update_ctrl: table memories with sync read, a transaction-level
// reference model (pending-report queue with computed retire cycles), and a few
// literal expectations from the worked examples.

module tb_bp_update_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_taken;
    logic        req1_valid, req1_ready, req1_taken;
    logic [31:0] req0_pc, req1_pc;
    logic [7:0]  bht_addr, pht_addr;
    logic        bht_we, pht_we;
    logic [3:0]  bht_wdata, bht_rdata;
    logic [1:0]  pht_wdata, pht_rdata;
    logic        init_done, busy;
`ifdef BP_UPD_STATS_EN
    logic [15:0] upd_count, bp_conflict_stall;
`endif

    always #5 clk = ~clk;

    bp_update_ctrl #(.HIST_W(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_pc(req0_pc), .req0_taken(req0_taken),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_pc(req1_pc), .req1_taken(req1_taken),
        .bht_addr(bht_addr), .bht_we(bht_we), .bht_wdata(bht_wdata),
        .bht_rdata(bht_rdata),
        .pht_addr(pht_addr), .pht_we(pht_we), .pht_wdata(pht_wdata),
        .pht_rdata(pht_rdata),
        .init_done(init_done),
`ifdef BP_UPD_STATS_EN
        .upd_count(upd_count), .bp_conflict_stall(bp_conflict_stall),
`endif
        .busy(busy)
    );

    // Table storage with 1-cycle read latency, plus backdoor pokes.
    logic [3:0] bht_mem [256];
    logic [1:0] pht_mem [256];
    logic       poke_b, poke_p;
    logic [7:0] poke_ba, poke_pa;
    logic [3:0] poke_bd;
    logic [1:0] poke_pd;

    always @(posedge clk) begin
        if (bht_we) bht_mem[bht_addr] <= bht_wdata;
        if (pht_we) pht_mem[pht_addr] <= pht_wdata;
        if (poke_b) bht_mem[poke_ba] <= poke_bd;
        if (poke_p) pht_mem[poke_pa] <= poke_pd;
        bht_rdata <= bht_mem[bht_addr];
        pht_rdata <= pht_mem[pht_addr];
    end

    // Reference model state.
    typedef struct {
        logic [7:0] idx;
        logic       tk;
        int         wr;
    } rep_t;

    rep_t       pend[$];
    logic [7:0] retire_log[$];
    logic [3:0] ref_bht [256];
    logic [1:0] ref_pht [256];
    int         cyc, free_at, exp_upd, exp_stall;
    bit         prio;
    int         checks, errors;

    logic       s_bht_we, s_pht_we, s_r0, s_r1;
    logic [7:0] s_bht_addr, s_pht_addr;
    logic [3:0] s_bht_wdata;
    logic [1:0] s_pht_wdata;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Compare DUT outputs for the current cycle against the model, then advance it.
    task automatic check_cycle();
        int  occ;
        bit  g0, g1, er0, er1;
        rep_t r;
        logic [3:0] h, nh;
        logic [7:0] pi;
        logic [1:0] c, nc;
        s_bht_we = bht_we; s_pht_we = pht_we; s_r0 = req0_ready; s_r1 = req1_ready;
        s_bht_addr = bht_addr; s_pht_addr = pht_addr;
        s_bht_wdata = bht_wdata; s_pht_wdata = pht_wdata;
        if (reset) begin
            chk("rst_bht_we", bht_we, 0);   chk("rst_pht_we", pht_we, 0);
            chk("rst_bht_addr", bht_addr, 0); chk("rst_pht_addr", pht_addr, 0);
            chk("rst_bht_wdata", bht_wdata, 0); chk("rst_pht_wdata", pht_wdata, 0);
            chk("rst_ready0", req0_ready, 0); chk("rst_ready1", req1_ready, 0);
            chk("rst_init_done", init_done, 0); chk("rst_busy", busy, 1);
`ifdef BP_UPD_STATS_EN
            chk("rst_upd_count", upd_count, 0);
            chk("rst_stall", bp_conflict_stall, 0);
`endif
            pend.delete(); prio = 0; free_at = 0; cyc = 0;
            exp_upd = 0; exp_stall = 0;
            return;
        end
`ifdef BP_UPD_STATS_EN
        chk("upd_count", upd_count, exp_upd);
        chk("conflict_stall", bp_conflict_stall, exp_stall);
`endif
        if (cyc < 256) begin
            chk("init_bht_we", bht_we, 1);   chk("init_pht_we", pht_we, 1);
            chk("init_bht_addr", bht_addr, cyc); chk("init_pht_addr", pht_addr, cyc);
            chk("init_bht_wdata", bht_wdata, 0); chk("init_pht_wdata", pht_wdata, 2);
            chk("init_ready0", req0_ready, 0); chk("init_ready1", req1_ready, 0);
            chk("init_done_low", init_done, 0); chk("init_busy", busy, 1);
            ref_bht[cyc] = 4'h0;
            ref_pht[cyc] = 2'b10;
        end else begin
            occ = pend.size();
            chk("init_done", init_done, 1);
            chk("busy", busy, (occ != 0) ? 1 : 0);
            g0  = req0_valid && (!req1_valid || !prio);
            g1  = req1_valid && (!req0_valid || prio);
            er0 = (occ < 4) && g0;
            er1 = (occ < 4) && g1;
            chk("ready0", req0_ready, er0);
            chk("ready1", req1_ready, er1);
            if (occ > 0 && pend[0].wr == cyc) begin
                r  = pend.pop_front();
                h  = ref_bht[r.idx];
                nh = {h[2:0], r.tk};
                pi = {h, r.idx[3:0]};
                c  = ref_pht[pi];
                if (r.tk) nc = (c == 2'd3) ? 2'd3 : c + 2'd1;
                else      nc = (c == 2'd0) ? 2'd0 : c - 2'd1;
                chk("wr_bht_we", bht_we, 1);      chk("wr_bht_addr", bht_addr, r.idx);
                chk("wr_bht_wdata", bht_wdata, nh);
                chk("wr_pht_we", pht_we, 1);      chk("wr_pht_addr", pht_addr, pi);
                chk("wr_pht_wdata", pht_wdata, nc);
                ref_bht[r.idx] = nh;
                ref_pht[pi]    = nc;
                retire_log.push_back(bht_addr);
                exp_upd++;
            end else begin
                chk("idle_bht_we", bht_we, 0);
                chk("idle_pht_we", pht_we, 0);
            end
            if ((req0_valid && !er0) || (req1_valid && !er1)) exp_stall++;
            if ((req0_valid && er0) || (req1_valid && er1)) begin
                r.idx = er0 ? req0_pc[11:4] : req1_pc[11:4];
                r.tk  = er0 ? req0_taken : req1_taken;
                r.wr  = ((cyc + 1 > free_at) ? cyc + 1 : free_at) + 2;
                free_at = r.wr + 1;
                pend.push_back(r);
                if (req0_valid && req1_valid) prio = !prio;
            end
        end
        if (poke_b) ref_bht[poke_ba] = poke_bd;
        if (poke_p) ref_pht[poke_pa] = poke_pd;
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        poke_b = 0;
        poke_p = 0;
    endtask

    task automatic idle(input int n);
        req0_valid = 0;
        req1_valid = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Preload a BHT/PHT pair, send one report alone, check its WR literally.
    task automatic send_one(input logic [7:0] idx, input logic tk,
                            input logic [3:0] bht0, input logic [7:0] pa,
                            input logic [1:0] pht0, input logic [3:0] eb,
                            input logic [1:0] ep);
        poke_b = 1; poke_ba = idx; poke_bd = bht0;
        poke_p = 1; poke_pa = pa;  poke_pd = pht0;
        step();
        req0_valid = 1; req0_pc = {20'h0, idx, 4'h0}; req0_taken = tk;
        step();
        chk("lit_accept", s_r0, 1);
        req0_valid = 0;
        step(); step(); step();
        chk("lit_bht_we", s_bht_we, 1);
        chk("lit_bht_addr", s_bht_addr, idx);
        chk("lit_bht_wdata", s_bht_wdata, eb);
        chk("lit_pht_addr", s_pht_addr, pa);
        chk("lit_pht_wdata", s_pht_wdata, ep);
        idle(2);
    endtask

    logic rd0 [6];
    logic rd1 [6];
    logic [7:0] exp_order [5];
    bit found;

    initial begin
        checks = 0; errors = 0; cyc = 0; free_at = 0; prio = 0;
        exp_upd = 0; exp_stall = 0;
        poke_b = 0; poke_p = 0; poke_ba = 0; poke_pa = 0; poke_bd = 0; poke_pd = 0;
        reset = 1;
        req0_valid = 0; req1_valid = 0; req0_pc = 0; req1_pc = 0;
        req0_taken = 0; req1_taken = 0;
        for (int i = 0; i < 3; i++) step();
        reset = 0;
        idle(258);

        // Worked example: BHT[A5]=0011 taken, PHT[35]=10 -> 0111 / 11.
        send_one(8'hA5, 1'b1, 4'b0011, 8'h35, 2'b10, 4'b0111, 2'b11);
        // Saturation at both ends.
        send_one(8'h10, 1'b0, 4'b0000, 8'h00, 2'b00, 4'b0000, 2'b00);
        send_one(8'h21, 1'b1, 4'b1111, 8'hF1, 2'b11, 4'b1111, 2'b11);

        // Both requesters valid for 6 cycles: alternating grants, queue fills.
        retire_log.delete();
        for (int k = 0; k < 6; k++) begin
            req0_valid = 1; req0_pc = {20'h0, 8'h60 + 8'(k), 4'h0}; req0_taken = k[0];
            req1_valid = 1; req1_pc = {20'h0, 8'h70 + 8'(k), 4'h0}; req1_taken = ~k[0];
            step();
            rd0[k] = s_r0;
            rd1[k] = s_r1;
        end
        idle(20);
        chk("rr_k0_r0", rd0[0], 1); chk("rr_k0_r1", rd1[0], 0);
        chk("rr_k1_r0", rd0[1], 0); chk("rr_k1_r1", rd1[1], 1);
        chk("rr_k2_r0", rd0[2], 1); chk("rr_k3_r1", rd1[3], 1);
        chk("rr_k4_r0", rd0[4], 1);
        chk("full_r0", rd0[5], 0);  chk("full_r1", rd1[5], 0);
        exp_order = '{8'h60, 8'h71, 8'h62, 8'h73, 8'h64};
        chk("retire_cnt", retire_log.size(), 5);
        for (int i = 0; i < 5 && i < retire_log.size(); i++)
            chk("retire_order", retire_log[i], exp_order[i]);

        // Reset while a report sits in RD_PHT with 3 entries queued.
        for (int k = 0; k < 4; k++) begin
            req0_valid = 1; req0_pc = {20'h0, 8'h80 + 8'(k), 4'h0}; req0_taken = 1;
            step();
        end
        req0_valid = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pend.size() >= 3 && pend[0].wr - 1 == cyc) found = 1;
            else step();
        end
        chk("rst_window_found", found, 1);
        reset = 1;
        step(); step();
        reset = 0;
        step();
        chk("reinit_addr0", s_bht_addr, 0);
        chk("reinit_we", s_bht_we, 1);
        idle(256);

        // Randomized traffic over a narrow index range to force aliasing.
        for (int i = 0; i < 1500; i++) begin
            req0_valid = ($urandom_range(0, 99) < 45);
            req1_valid = ($urandom_range(0, 99) < 45);
            req0_pc    = $urandom() & 32'hFFFF_F3FF;
            req1_pc    = $urandom() & 32'hFFFF_F3FF;
            req0_taken = $urandom_range(0, 1);
            req1_taken = $urandom_range(0, 1);
            step();
        end
        idle(20);
        chk("drained", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_update_ctrl.md
# bp_update_ctrl

Update sequencer for the two-level branch predictor tables: the 256-entry BHT (per-branch history registers) and the 256-entry PHT (2-bit saturating counters). It clears both tables after reset, then accepts branch-resolution reports from two execution-unit requesters through a round-robin arbiter into a 4-entry FIFO. It retires each report as a strictly ordered read-modify-write sequence on the tables' single update port. It sits between the branch units and the predictor storage; the predictor's lookup path is not touched.

## Interface
Parameters:
- `HIST_W`, default 4: BHT entry width (history bits); PHT index uses `HIST_W` history bits plus `8-HIST_W` PC bits.
- `FIFO_DEPTH`, default 4: report queue depth (power of 2).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a resolved branch.
- `req0_ready`  out  1  requester 0 report accepted this cycle when valid&ready.
- `req0_pc`  in  32  branch PC.
- `req0_taken`  in  1  resolved direction, 1 = taken.
- `req1_valid`, `req1_ready`, `req1_pc`, `req1_taken`: same as above, for requester 1.
- `bht_addr`  out  8  BHT update-port address.
- `bht_we`  out  1  BHT write enable.
- `bht_wdata`  out  `HIST_W`  BHT write data.
- `bht_rdata`  in  `HIST_W`  BHT synchronous read data, valid 1 cycle after `bht_addr` is presented.
- `pht_addr`  out  8  PHT update-port address.
- `pht_we`  out  1  PHT write enable.
- `pht_wdata`  out  2  PHT write data.
- `pht_rdata`  in  2  PHT synchronous read data, 1-cycle latency.
- `init_done`  out  1  table clear complete.
- `busy`  out  1  in INIT, or FIFO non-empty, or an update in flight.

## Operation
- States:
  - `INIT`: clear sweep.
  - `IDLE`: waiting for a report.
  - `RD_BHT`: issue BHT read.
  - `RD_PHT`: issue PHT read.
  - `WR`: write both tables.
- `INIT`:
  - `init_idx` counts 0..255.
  - Each cycle: `bht_we=1`, `bht_wdata=0`, `pht_we=1`, `pht_wdata=2'b10` (weakly taken), both addresses = `init_idx`.
  - At `init_idx==255`, go to `IDLE` and set `init_done=1`.
  - Both readies are 0 during `INIT`.
- Arbitration and FIFO:
  - At most one enqueue per cycle.
  - `reqN_ready = init_done & (count<FIFO_DEPTH) & grantN`.
  - With one requester valid, it is granted.
  - With both valid, the priority pointer is granted, and the pointer then flips to the other requester.
  - The pointer resets to requester 0.
  - `ready` depends combinationally on `valid`.
  - A FIFO entry holds `{pc[11:4], taken}`.
  - `count` is registered; a slot freed by a pop is usable the next cycle.
  - Simultaneous push and pop leaves `count` unchanged.
- Update sequence (head entry, index `i=pc[11:4]`):
  - `RD_BHT`: `bht_addr=i`.
  - `RD_PHT`: latch `h=bht_rdata`; `pht_addr={h, i[7-HIST_W:0]}`.
  - `WR`:
    - `bht_addr=i`, `bht_we=1`, `bht_wdata={h[HIST_W-2:0], taken}`.
    - `pht_addr` held from `RD_PHT`, `pht_we=1`.
    - `pht_wdata`: if taken, `min(3, c+1)`; if not taken, `max(0, c-1)`, where `c=pht_rdata`.
    - FIFO pops.
  - After `WR`: go to `RD_BHT` if the FIFO still holds an entry after the pop, else `IDLE`.
  - `IDLE` goes to `RD_BHT` when `count>0`.
- Ordering: reports retire in FIFO order. The next report's reads follow the previous report's write edge, so there is no RAW hazard and no forwarding is needed.
- Reset in any state:
  - State goes to `INIT`, `init_idx=0`, FIFO is flushed, priority resets to requester 0.
  - The in-flight update is dropped; no partial write is issued.
  - The sweep restarts from 0.
- Reset values while `reset=1`:
  - `bht_we=0`, `pht_we=0`.
  - `bht_addr=0`, `pht_addr=0`, `bht_wdata=0`, `pht_wdata=0`.
  - Both readies 0, `init_done=0`, `busy=1`.

## Timing
- Reset deasserted before edge E0: INIT writes occupy cycles 0..255, and `init_done=1` from cycle 256.
- Report accepted at edge of cycle t with FIFO empty and state `IDLE`:
  - `RD_BHT` at t+1, `RD_PHT` at t+2, `WR` at t+3.
  - Tables are updated at the end of t+3.
- Sustained throughput: 1 report per 3 cycles (`WR` goes directly to `RD_BHT`).
- FIFO full: both readies are 0 until the cycle after the next `WR` pop.

## Configuration
- Macro `BP_UPD_STATS_EN`.
- Defined: adds output `upd_count[15:0]` and output `bp_conflict_stall[15:0]`.
  - `upd_count` increments on each `WR`.
  - `bp_conflict_stall` increments on each cycle where any `reqN_valid` is high and `reqN_ready` is low while `init_done=1`.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

## Test plan
- Reset released:
  - Exactly 256 cycles with `bht_we=pht_we=1` at addresses 0..255, with wdata 0 and 2'b10.
  - `init_done` rises at cycle 256.
  - Readies are 0 throughout.
- Single report `pc=32'h0000_0A50`, taken, BHT model entry 0xA5 = 4'b0011, PHT[{4'b0011, 4'h5}] = 2'b10:
  - At t+3: `bht_wdata=4'b0111` at 0xA5.
  - `pht_wdata=2'b11` at 0x35.
- Saturation: not-taken on a counter at 2'b00 writes 2'b00; taken on 2'b11 writes 2'b11.
- Both requesters valid for 6 consecutive cycles with the queue draining:
  - Grants alternate 0,1,0,1….
  - Retirement order matches grant order.
  - Queue fills to 4 and readies drop to 0 until the pop.
- Reset asserted during `RD_PHT` with 3 entries queued:
  - No `WR` occurs; FIFO is empty.
  - INIT restarts at address 0.
- With `BP_UPD_STATS_EN`: 5 retired reports give `upd_count=5`; one cycle of blocked valid increments `bp_conflict_stall` by 1.
